// File: rtl/axis2sgdma_ic_pkg.sv
// ============================================================================
// Module      : axis2sgdma_ic_pkg
// Description : Shared state encoding, status-word constants and popcount
//               helper for the AXI Stream to SG-DMA S2MM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis2sgdma_ic_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_PASS   = 2'd1;
    localparam state_t ST_STATUS = 2'd2;

    localparam int          STS_WORDS = 5;
    localparam logic [31:0] STS_FLAG  = 32'h5000_0000;

    localparam logic [2:0] W_FLAG  = 3'd0;
    localparam logic [2:0] W_RSVD  = 3'd1;
    localparam logic [2:0] W_TDEST = 3'd2;
    localparam logic [2:0] W_PCNT  = 3'd3;
    localparam logic [2:0] W_LEN   = 3'd4;

    // Widest byte-enable vector the helper handles (1024-bit data path).
    localparam int POPCNT_MAX_W = 128;

    function automatic logic [7:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            r = r + 8'(v[i]);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis2sgdma_ic_popcnt.sv
// ============================================================================
// Module      : axis2sgdma_ic_popcnt
// Description : Purely combinational count of set bits in a tkeep vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis2sgdma_ic_popcnt
    import axis2sgdma_ic_pkg::*;
#(
    parameter int KEEP_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  cnt
);

    logic [POPCNT_MAX_W-1:0] w_keep_ext;

    assign w_keep_ext = POPCNT_MAX_W'(keep);
    assign cnt        = CNT_W'(popcount(w_keep_ext));

endmodule

`default_nettype wire

// File: rtl/axis2sgdma_ic.sv
// ============================================================================
// Module      : axis2sgdma_ic
// Description : Router-to-DMA return bridge; forwards packets and appends a
//               5-word status stream (flag, 0, tdest, pkt count/0, bytes).
//               Optional macro AXIS2SGDMA_IC_PKT_CNT_EN enables packet count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis2sgdma_ic
    import axis2sgdma_ic_pkg::*;
#(
    parameter int DATA_TDATA_WIDTH = 64,
    parameter int CTRL_TDATA_WIDTH = 32,
    parameter int TDEST_WIDTH      = 4
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [DATA_TDATA_WIDTH-1:0]   axis_tdata,
    input  logic                          axis_tvalid,
    input  logic                          axis_tlast,
    output logic                          axis_tready,
    input  logic [DATA_TDATA_WIDTH/8-1:0] axis_tkeep,
    input  logic [TDEST_WIDTH-1:0]        axis_tdest,
    output logic [DATA_TDATA_WIDTH-1:0]   data_tdata,
    output logic                          data_tvalid,
    output logic                          data_tlast,
    input  logic                          data_tready,
    output logic [DATA_TDATA_WIDTH/8-1:0] data_tkeep,
    output logic [CTRL_TDATA_WIDTH-1:0]   sts_tdata,
    output logic                          sts_tvalid,
    output logic                          sts_tlast,
    input  logic                          sts_tready,
    output logic [CTRL_TDATA_WIDTH/8-1:0] sts_tkeep
);

    localparam int KEEP_W = DATA_TDATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(KEEP_W + 1);
    localparam logic [CTRL_TDATA_WIDTH-1:0] C_FLAG = CTRL_TDATA_WIDTH'(STS_FLAG);

    state_t                      r_state;
    logic [TDEST_WIDTH-1:0]      r_tdest;
    logic [CTRL_TDATA_WIDTH-1:0] r_byte_cnt;
    logic [2:0]                  r_idx;
    logic [CTRL_TDATA_WIDTH-1:0] w_pkt_cnt;

    logic [CNT_W-1:0]            w_beat_bytes;
    logic [CTRL_TDATA_WIDTH:0]   w_sum;
    logic [CTRL_TDATA_WIDTH-1:0] w_cnt_next;
    logic                        w_in_status;
    logic                        w_accept;
    logic                        w_sts_hs;
    logic                        w_sts_done;

    axis2sgdma_ic_popcnt #(
        .KEEP_W (KEEP_W),
        .CNT_W  (CNT_W)
    ) u_popcnt (
        .keep (axis_tkeep),
        .cnt  (w_beat_bytes)
    );

    assign w_in_status = (r_state == ST_STATUS);

    // Handshake outputs are forced low while reset is asserted.
    assign axis_tready = arstn & ~w_in_status & data_tready;
    assign data_tvalid = arstn & ~w_in_status & axis_tvalid;
    assign data_tdata  = axis_tdata;
    assign data_tkeep  = axis_tkeep;
    assign data_tlast  = axis_tlast;
    assign w_accept    = axis_tvalid & axis_tready;

    assign sts_tvalid  = arstn & w_in_status;
    assign sts_tlast   = w_in_status & (r_idx == W_LEN);
    assign sts_tkeep   = '1;
    assign w_sts_hs    = sts_tvalid & sts_tready;
    assign w_sts_done  = w_sts_hs & (r_idx == W_LEN);

    // Saturating byte accumulation; the IDLE case starts from zero.
    always_comb begin
        w_sum = {1'b0, (r_state == ST_IDLE) ? '0 : r_byte_cnt}
              + (CTRL_TDATA_WIDTH + 1)'(w_beat_bytes);
        w_cnt_next = w_sum[CTRL_TDATA_WIDTH] ? '1 : w_sum[CTRL_TDATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state    <= ST_IDLE;
            r_tdest    <= '0;
            r_byte_cnt <= '0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tdest    <= axis_tdest;
                        r_byte_cnt <= w_cnt_next;
                        r_state    <= axis_tlast ? ST_STATUS : ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_accept) begin
                        r_byte_cnt <= w_cnt_next;
                        if (axis_tlast) begin
                            r_state <= ST_STATUS;
                        end
                    end
                end
                ST_STATUS: begin
                    if (w_sts_hs) begin
                        if (w_sts_done) begin
                            r_idx      <= '0;
                            r_byte_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS2SGDMA_IC_PKT_CNT_EN
    logic [CTRL_TDATA_WIDTH-1:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_pkt_cnt <= '0;
        end else if (w_sts_done) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign w_pkt_cnt = r_pkt_cnt;
`else
    assign w_pkt_cnt = '0;
`endif

    always_comb begin
        sts_tdata = '0;
        case (r_idx)
            W_FLAG:  sts_tdata = C_FLAG;
            W_RSVD:  sts_tdata = '0;
            W_TDEST: sts_tdata = CTRL_TDATA_WIDTH'(r_tdest);
            W_PCNT:  sts_tdata = w_pkt_cnt;
            W_LEN:   sts_tdata = r_byte_cnt;
            default: sts_tdata = '0;
        endcase
    end

endmodule

`default_nettype wire
